// File: rtl/tuner_phy_ctrl_arb.sv
// Shared heater-DAC arbiter for the SEARCH and LOCK tuner controllers of one ring.
// Grants one channel, drives its code, settles, fetches one power sample, returns it.
//
// state  | meaning
// INIT   | idle; arbitrate sampled requests (round-robin on a tie)
// TUNE   | one cycle: DAC update strobe with the winner's code
// SYNC   | settle countdown, then hold o_pwr_req until a sample or timeout
// COMMIT | one cycle: done/err/pwr to the granted channel
module tuner_phy_ctrl_arb #(
  parameter int CODE_WIDTH     = 8,
  parameter int PWR_WIDTH      = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            i_ch_req,
  input  logic [CODE_WIDTH-1:0] i_ch_code_search,
  input  logic [CODE_WIDTH-1:0] i_ch_code_lock,
  output logic [1:0]            o_ch_gnt,
  output logic [1:0]            o_ch_done,
  output logic                  o_ch_err,
  output logic [PWR_WIDTH-1:0]  o_ch_pwr,
  output logic [CODE_WIDTH-1:0] o_tuner_code,
  output logic                  o_tuner_valid,
  output logic                  o_pwr_req,
  input  logic                  i_pwr_valid,
  input  logic [PWR_WIDTH-1:0]  i_pwr,
  output logic [1:0]            o_state
);

  typedef enum logic {CH_SEARCH = 1'b0, CH_LOCK = 1'b1} tuner_ctrl_ch_e;
  typedef enum logic [1:0] {
    ARB_CTRL_INIT   = 2'd0,
    ARB_CTRL_TUNE   = 2'd1,
    ARB_CTRL_SYNC   = 2'd2,
    ARB_CTRL_COMMIT = 2'd3
  } tuner_phy_ctrl_arb_state_e;

  localparam int SW = $clog2((SETTLE_CYCLES > 1) ? SETTLE_CYCLES : 1) + 1;
  localparam int TW = $clog2((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 1) + 1;
  localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  tuner_phy_ctrl_arb_state_e state_q, state_d;
  tuner_ctrl_ch_e            last_q, last_d, win;
  logic [SW-1:0]             settle_q, settle_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [1:0]                gnt_d, done_d;
  logic                      err_d, tvalid_d, preq_d;
  logic [PWR_WIDTH-1:0]      pwr_d;
  logic [CODE_WIDTH-1:0]     code_d;

  assign o_state = state_q;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    gnt_d    = o_ch_gnt;
    done_d   = '0;
    err_d    = 1'b0;
    pwr_d    = '0;
    code_d   = o_tuner_code;
    tvalid_d = 1'b0;
    preq_d   = o_pwr_req;
    if (i_ch_req == 2'b11) win = (last_q == CH_LOCK) ? CH_SEARCH : CH_LOCK;
    else                   win = i_ch_req[1] ? CH_LOCK : CH_SEARCH;

    case (state_q)
      ARB_CTRL_INIT: begin
        if (i_ch_req != 2'b00) begin
          gnt_d    = (win == CH_LOCK) ? 2'b10 : 2'b01;
          code_d   = (win == CH_LOCK) ? i_ch_code_lock : i_ch_code_search;
          tvalid_d = 1'b1;
          state_d  = ARB_CTRL_TUNE;
        end
      end
      ARB_CTRL_TUNE: begin
        settle_d = SETTLE_LOAD;
        state_d  = ARB_CTRL_SYNC;
      end
      ARB_CTRL_SYNC: begin
        // o_pwr_req low means still settling; high means waiting for a sample
        if (!o_pwr_req) begin
          if (settle_q != '0) begin
            settle_d = settle_q - SW'(1);
          end else begin
            preq_d = 1'b1;
            tmo_d  = TIMEOUT_LOAD;
          end
        end else if (i_pwr_valid) begin
          preq_d  = 1'b0;
          pwr_d   = i_pwr;
          done_d  = o_ch_gnt;
          state_d = ARB_CTRL_COMMIT;
        end else if (tmo_q == '0) begin
          preq_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = o_ch_gnt;
          state_d = ARB_CTRL_COMMIT;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ARB_CTRL_COMMIT: begin
        last_d  = o_ch_gnt[1] ? CH_LOCK : CH_SEARCH;
        gnt_d   = 2'b00;
        state_d = ARB_CTRL_INIT;
      end
      default: state_d = ARB_CTRL_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_CTRL_INIT;
      last_q        <= CH_LOCK;
      settle_q      <= '0;
      tmo_q         <= '0;
      o_ch_gnt      <= '0;
      o_ch_done     <= '0;
      o_ch_err      <= 1'b0;
      o_ch_pwr      <= '0;
      o_tuner_code  <= '0;
      o_tuner_valid <= 1'b0;
      o_pwr_req     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      settle_q      <= settle_d;
      tmo_q         <= tmo_d;
      o_ch_gnt      <= gnt_d;
      o_ch_done     <= done_d;
      o_ch_err      <= err_d;
      o_ch_pwr      <= pwr_d;
      o_tuner_code  <= code_d;
      o_tuner_valid <= tvalid_d;
      o_pwr_req     <= preq_d;
    end
  end

endmodule
